// File: rtl/pim_conv_ctrl_pkg.sv
// Shared definitions for the PIM convolution controller.
// Holds the controller state encoding and the default crossbar latency.
// Imported by the controller; the crossbar itself lives in the parent.
package pim_conv_ctrl_pkg;

   // Default cycles from the pim_en cycle to a valid pim_out (legal 1..15)
   localparam int PIM_LAT_DEF = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      OUT   = 3'd4,
      DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/pim_conv_ctrl.sv
// Sweeps one input vector across crossbar addresses 0..last_addr and streams one ADC result per address.
// Latency: ISSUE (1) + PIM_LAT wait cycles + OUT, so back-to-back addresses are PIM_LAT+2 cycles apart.
// Backpressure: OUT holds res_valid/res_data/res_addr/res_last until res_ready; no further crossbar access meanwhile.
module pim_conv_ctrl
   import pim_conv_ctrl_pkg::*;
#(
   parameter int INPUT_SIZE = 64,
   parameter int DEPTH      = 6,
   parameter int ADC_P      = 8,
   parameter int PIM_LAT    = PIM_LAT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DEPTH-1:0]      last_addr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INPUT_SIZE-1:0] in_data,
   output logic                  pim_en,
   output logic [DEPTH-1:0]      pim_addr,
   output logic [INPUT_SIZE-1:0] pim_feature,
   input  logic [ADC_P-1:0]      pim_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ADC_P-1:0]      res_data,
   output logic [DEPTH-1:0]      res_addr,
   output logic                  res_last,
   output logic                  busy,
   output logic                  done
);

   // Wait counter is 4 bits wide: PIM_LAT never exceeds 15
   localparam logic [3:0] LAT_CNT = 4'(PIM_LAT);

   state_t                state_q, state_d;
   logic [DEPTH-1:0]      cnt_q;
   logic [DEPTH-1:0]      last_q;
   logic [INPUT_SIZE-1:0] vec_q;
   logic [3:0]            wait_q;
   logic [ADC_P-1:0]      res_data_q;
   logic [DEPTH-1:0]      res_addr_q;

   logic wait_done;
   logic at_last;

   // wait_q counts cycles since ISSUE; pim_out is valid when it reaches PIM_LAT
   assign wait_done = (wait_q == LAT_CNT);
   assign at_last   = (cnt_q == last_q);

   assign pim_addr    = cnt_q;
   assign pim_feature = vec_q;
   assign res_data    = res_data_q;
   assign res_addr    = res_addr_q;
   assign res_last    = res_valid & at_last;

   // State register; reset abandons any job in flight
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and per-state handshake/strobe outputs
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      pim_en    = 1'b0;
      res_valid = 1'b0;
      done      = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE:  if (start) state_d = LOAD;
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ISSUE;
         end
         ISSUE: begin
            pim_en  = 1'b1;
            state_d = WAIT;
         end
         WAIT:  if (wait_done) state_d = OUT;
         OUT: begin
            res_valid = 1'b1;
            if (res_ready) state_d = at_last ? DONE : ISSUE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: job parameters, input vector, address counter and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         last_q     <= '0;
         vec_q      <= '0;
         wait_q     <= '0;
         res_data_q <= '0;
         res_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  last_q <= last_addr;
                  cnt_q  <= '0;
               end
            end
            LOAD:  if (in_valid) vec_q <= in_data;
            ISSUE: wait_q <= 4'd1;
            WAIT: begin
               if (wait_done) begin
                  res_data_q <= pim_out;
                  res_addr_q <= cnt_q;
               end else begin
                  wait_q <= wait_q + 4'd1;
               end
            end
            // Counter stops at last_q, so a full 2^DEPTH sweep never wraps
            OUT: if (res_ready && !at_last) cnt_q <= cnt_q + {{(DEPTH-1){1'b0}}, 1'b1};
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pim_conv_ctrl.sv
// Scoreboard bench for pim_conv_ctrl with a latency-accurate crossbar model.
// Stimulus enqueues expected results per job; the negedge monitor checks every transfer and issue.
// Every wait on the DUT is bounded by a cycle budget.
module tb_pim_conv_ctrl;

   localparam int INPUT_SIZE = 64;
   localparam int DEPTH      = 6;
   localparam int ADC_P      = 8;
   localparam int LAT        = 3;

   logic                  clk = 1'b0;
   logic                  rst, start, in_valid, in_ready, pim_en;
   logic                  res_valid, res_ready, res_last, busy, done;
   logic [DEPTH-1:0]      last_addr, pim_addr, res_addr;
   logic [INPUT_SIZE-1:0] in_data, pim_feature;
   logic [ADC_P-1:0]      pim_out, res_data;

   typedef struct packed {
      logic [DEPTH-1:0] addr;
      logic [ADC_P-1:0] data;
      logic             last;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int pe_cnt = 0;
   int done_cnt = 0;
   int next_issue = 0;
   int last_pe_cyc = 0;
   logic lat_pend = 1'b0;
   logic spacing_en = 1'b0;
   logic [INPUT_SIZE-1:0] exp_vec = '0;
   logic [ADC_P-1:0] off = '0;
   logic resp_pend = 1'b0;
   int resp_cyc = 0;
   logic [ADC_P-1:0] resp_val = '0;

   always #5 clk = ~clk;

   pim_conv_ctrl #(
      .INPUT_SIZE(INPUT_SIZE),
      .DEPTH     (DEPTH),
      .ADC_P     (ADC_P),
      .PIM_LAT   (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .last_addr  (last_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .pim_en     (pim_en),
      .pim_addr   (pim_addr),
      .pim_feature(pim_feature),
      .pim_out    (pim_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_addr   (res_addr),
      .res_last   (res_last),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Crossbar model: pim_out carries addr+off exactly LAT cycles after the pim_en cycle, junk otherwise
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      pim_out = (resp_pend && cyc == resp_cyc) ? resp_val : 8'hEE;
   end

   // Monitor: issue ordering/spacing, result latency, and scoreboard pops on each accepted result
   always @(negedge clk) begin
      if (rst) begin
         lat_pend  = 1'b0;
         resp_pend = 1'b0;
      end else begin
         if (pim_en) begin
            pe_cnt++;
            chk("issue_addr", 64'(pim_addr), 64'(next_issue));
            chk("issue_feature", pim_feature, exp_vec);
            if (next_issue != 0 && spacing_en)
               chk("issue_spacing", 64'(cyc - last_pe_cyc), 64'(LAT + 2));
            next_issue++;
            last_pe_cyc = cyc;
            lat_pend    = 1'b1;
            resp_pend   = 1'b1;
            resp_cyc    = cyc + LAT;
            resp_val    = ADC_P'(pim_addr) + off;
         end
         if (res_valid && lat_pend) begin
            chk("first_valid_latency", 64'(cyc - last_pe_cyc), 64'(LAT + 1));
            lat_pend = 1'b0;
         end
         if (!res_valid) chk("res_last_without_valid", 64'(res_last), 64'd0);
         if (res_valid && res_ready) begin
            chk("result_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               chk("res_addr", 64'(res_addr), 64'(mon_e.addr));
               chk("res_data", 64'(res_data), 64'(mon_e.data));
               chk("res_last", 64'(res_last), 64'(mon_e.last));
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_in_ready"},    64'(in_ready),  64'd0);
      chk({tag, "_pim_en"},      64'(pim_en),    64'd0);
      chk({tag, "_res_valid"},   64'(res_valid), 64'd0);
      chk({tag, "_res_last"},    64'(res_last),  64'd0);
      chk({tag, "_busy"},        64'(busy),      64'd0);
      chk({tag, "_done"},        64'(done),      64'd0);
      chk({tag, "_pim_addr"},    64'(pim_addr),  64'd0);
      chk({tag, "_pim_feature"}, pim_feature,    64'd0);
      chk({tag, "_res_data"},    64'(res_data),  64'd0);
      chk({tag, "_res_addr"},    64'(res_addr),  64'd0);
   endtask

   task automatic push_job(input logic [DEPTH-1:0] la, input logic [ADC_P-1:0] o);
      exp_t e;
      for (int a = 0; a <= int'(la); a++) begin
         e.addr = DEPTH'(a);
         e.data = ADC_P'(a) + o;
         e.last = (a == int'(la));
         sb_q.push_back(e);
      end
   endtask

   // Runs one job; entered and left just after a rising edge, leaving the DUT in the IDLE cycle after DONE
   task automatic run_job(input logic [DEPTH-1:0] la, input logic [INPUT_SIZE-1:0] vec,
                          input int in_dly, input int stall, input logic [ADC_P-1:0] o);
      int pe0, dn0, pe_st, ir_hold, pe_bad, st_bad, t;
      logic [ADC_P-1:0] d0;
      chk("idle_before_start_busy", 64'(busy), 64'd0);
      chk("idle_before_start_done", 64'(done), 64'd0);
      off        = o;
      exp_vec    = vec;
      next_issue = 0;
      spacing_en = (stall == 0);
      push_job(la, o);
      pe0 = pe_cnt;
      dn0 = done_cnt;
      res_ready = (stall == 0);
      start = 1'b1;
      last_addr = la;
      @(posedge clk); #1;
      start = 1'b0;
      last_addr = ~la;
      ir_hold = 0;
      pe_bad  = 0;
      repeat (in_dly) begin
         @(negedge clk);
         if (in_ready) ir_hold++;
         if (pim_en) pe_bad++;
         @(posedge clk); #1;
      end
      if (in_dly > 0) begin
         chk("in_ready_held", 64'(ir_hold), 64'(in_dly));
         chk("no_issue_before_capture", 64'(pe_bad), 64'd0);
      end
      in_valid = 1'b1;
      in_data  = vec;
      @(negedge clk);
      chk("in_ready_in_load", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~vec;
      if (stall > 0) begin
         t = 0;
         do begin @(negedge clk); t++; end while (!res_valid && t < 200);
         chk("stall_valid_seen", 64'(res_valid), 64'd1);
         d0     = res_data;
         pe_st  = pe_cnt;
         st_bad = 0;
         chk("stall_first_data", 64'(d0), 64'(o));
         repeat (stall - 1) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!res_valid || res_data !== d0 || res_addr !== '0) st_bad++;
         end
         chk("stall_outputs_stable", 64'(st_bad), 64'd0);
         chk("stall_no_new_issue", 64'(pe_cnt - pe_st), 64'd0);
         @(posedge clk); #1;
         res_ready = 1'b1;
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!done && t < 2000);
      chk("done_seen", 64'(done), 64'd1);
      @(posedge clk); #1;
      chk("done_pulses", 64'(done_cnt - dn0), 64'd1);
      chk("issue_count", 64'(pe_cnt - pe0), 64'(int'(la) + 1));
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
   endtask

   // Aborts a last_addr=3 job with reset in the WAIT of address 2, start asserted alongside reset
   task automatic abort_job();
      int t;
      off        = 8'h20;
      exp_vec    = 64'h5A5A_0F0F_C3C3_9696;
      next_issue = 0;
      spacing_en = 1'b1;
      res_ready  = 1'b1;
      push_job(6'd3, 8'h20);
      start = 1'b1;
      last_addr = 6'd3;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      in_data = exp_vec;
      @(posedge clk); #1;
      in_valid = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!(pim_en && pim_addr == 6'd2) && t < 200);
      chk("abort_issue2_seen", 64'(pim_en && pim_addr == 6'd2), 64'd1);
      @(posedge clk); #1;
      chk("abort_in_wait_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_zero("abort");
      sb_q.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      last_addr = '0;
      in_valid = 1'b0;
      in_data = '0;
      res_ready = 1'b0;
      pim_out = 8'hEE;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      // four addresses, results 0x10..0x13
      run_job(6'd3,  64'h0123_4567_89AB_CDEF, 0, 0, 8'h10);
      // single address, started in the cycle right after DONE; MSB-set data
      run_job(6'd0,  64'hDEAD_BEEF_0000_FFFF, 0, 0, 8'hF0);
      // first result held 5 cycles by res_ready=0
      run_job(6'd1,  64'hA5A5_A5A5_5A5A_5A5A, 0, 5, 8'h30);
      // input vector arrives 7 cycles after start
      run_job(6'd2,  64'h8000_0000_0000_0001, 7, 0, 8'h50);
      // reset mid-job, then a fresh job from address 0
      abort_job();
      run_job(6'd3,  64'h1111_2222_3333_4444, 0, 0, 8'h60);
      // full sweep, no wrap
      run_job(6'd63, 64'hFEDC_BA98_7654_3210, 0, 0, 8'h40);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
